// File: rtl/axi2gpu.sv
// axi2gpu: AXI4-Lite register file feeding a raster-scan VGA generator that
// composites up to four solid-colour rectangles over a background colour.
module axi2gpu #(
    parameter int C_S00_AXI_DATA_WIDTH = 32,
    parameter int C_S00_AXI_ADDR_WIDTH = 7,
    parameter int CLK_DIV              = 4,
    parameter int H_ACTIVE             = 640,
    parameter int H_FP                 = 16,
    parameter int H_SYNC               = 96,
    parameter int H_BP                 = 48,
    parameter int V_ACTIVE             = 480,
    parameter int V_FP                 = 10,
    parameter int V_SYNC               = 2,
    parameter int V_BP                 = 33
) (
    input  logic                                s00_axi_aclk,
    input  logic                                s00_axi_aresetn,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                          s00_axi_awprot,
    input  logic                                s00_axi_awvalid,
    output logic                                s00_axi_awready,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S00_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                                s00_axi_wvalid,
    output logic                                s00_axi_wready,
    output logic [1:0]                          s00_axi_bresp,
    output logic                                s00_axi_bvalid,
    input  logic                                s00_axi_bready,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                          s00_axi_arprot,
    input  logic                                s00_axi_arvalid,
    output logic                                s00_axi_arready,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                          s00_axi_rresp,
    output logic                                s00_axi_rvalid,
    input  logic                                s00_axi_rready,
    output logic [11:0]                         pixel_send,
    output logic                                h_sync,
    output logic                                v_sync
);

    localparam int IDX_W   = C_S00_AXI_ADDR_WIDTH - 2;
    localparam int N_REGS  = 2 ** IDX_W;
    localparam int N_BYTES = C_S00_AXI_DATA_WIDTH / 8;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]       V_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0]       HS_FIRST  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]       HS_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]       VS_FIRST  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]       VS_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0]       H_ACT_END = 10'(H_ACTIVE);
    localparam logic [9:0]       V_ACT_END = 10'(V_ACTIVE);

    logic [C_S00_AXI_DATA_WIDTH-1:0] r_regs [N_REGS];

    logic                            r_awready;
    logic                            r_wready;
    logic                            r_bvalid;
    logic                            r_arready;
    logic                            r_rvalid;
    logic [C_S00_AXI_DATA_WIDTH-1:0] r_rdata;

    logic [DIV_W-1:0]                r_div;
    logic [9:0]                      r_hcnt;
    logic [9:0]                      r_vcnt;
    logic [11:0]                     r_pixel;
    logic                            r_hsync;
    logic                            r_vsync;

    logic                            w_wr_hs;
    logic                            w_rd_hs;
    logic [IDX_W-1:0]                w_wr_idx;
    logic [IDX_W-1:0]                w_rd_idx;
    logic                            w_tick;
    logic [3:0]                      w_hit;
    logic [3:0][11:0]                w_spr_col;
    logic [11:0]                     w_color;
    logic                            w_active;
    logic                            w_unused;

    assign w_wr_hs  = r_awready & s00_axi_awvalid & s00_axi_wvalid;
    assign w_rd_hs  = r_arready & s00_axi_arvalid;
    assign w_wr_idx = s00_axi_awaddr[C_S00_AXI_ADDR_WIDTH-1:2];
    assign w_rd_idx = s00_axi_araddr[C_S00_AXI_ADDR_WIDTH-1:2];
    assign w_unused = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0],
                        s00_axi_araddr[1:0]};

    assign s00_axi_awready = r_awready;
    assign s00_axi_wready  = r_wready;
    assign s00_axi_bresp   = 2'b00;
    assign s00_axi_bvalid  = r_bvalid;
    assign s00_axi_arready = r_arready;
    assign s00_axi_rdata   = r_rdata;
    assign s00_axi_rresp   = 2'b00;
    assign s00_axi_rvalid  = r_rvalid;
    assign pixel_send      = r_pixel;
    assign h_sync          = r_hsync;
    assign v_sync          = r_vsync;

    // Write channel: one-cycle aw/w ready pulse, then hold bvalid until bready.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
        end else begin
            r_awready <= !r_awready && !r_bvalid && s00_axi_awvalid && s00_axi_wvalid;
            r_wready  <= !r_awready && !r_bvalid && s00_axi_awvalid && s00_axi_wvalid;
            if (w_wr_hs) begin
                r_bvalid <= 1'b1;
            end else if (s00_axi_bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // Register file: byte-lane writes committed on the aw/w handshake edge.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            for (int i = 0; i < N_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_hs) begin
            for (int b = 0; b < N_BYTES; b++) begin
                if (s00_axi_wstrb[b]) begin
                    r_regs[w_wr_idx][8*b +: 8] <= s00_axi_wdata[8*b +: 8];
                end
            end
        end
    end

    // Read channel: one-cycle arready pulse, data captured at the handshake.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_arready <= !r_arready && !r_rvalid && s00_axi_arvalid;
            if (w_rd_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= r_regs[w_rd_idx];
            end else if (s00_axi_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    assign w_tick = (r_div == DIV_LAST);

    // Pixel-rate divider and raster scan counters.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_div  <= '0;
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (w_tick) begin
            r_div <= '0;
            if (r_hcnt == H_LAST) begin
                r_hcnt <= '0;
                r_vcnt <= (r_vcnt == V_LAST) ? 10'd0 : r_vcnt + 10'd1;
            end else begin
                r_hcnt <= r_hcnt + 10'd1;
            end
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Sprite hit tests; 11-bit compares so x+width and y+height never wrap.
    for (genvar g = 0; g < 4; g++) begin : g_spr
        logic [10:0] w_x0;
        logic [10:0] w_x1;
        logic [10:0] w_y0;
        logic [10:0] w_y1;
        logic [10:0] w_h;
        logic [10:0] w_v;

        assign w_x0 = {1'b0, r_regs[4+3*g][9:0]};
        assign w_y0 = {1'b0, r_regs[4+3*g][19:10]};
        assign w_x1 = w_x0 + {1'b0, r_regs[4+3*g][29:20]};
        assign w_y1 = w_y0 + {1'b0, r_regs[5+3*g][9:0]};
        assign w_h  = {1'b0, r_hcnt};
        assign w_v  = {1'b0, r_vcnt};

        assign w_spr_col[g] = r_regs[5+3*g][21:10];
        assign w_hit[g]     = r_regs[3][g] && (w_h >= w_x0) && (w_h < w_x1) &&
                              (w_v >= w_y0) && (w_v < w_y1);
    end

    // Priority select: walk from sprite 3 down so the lowest index wins.
    always_comb begin
        w_color = r_regs[0][11:0];
        for (int i = 3; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_color = w_spr_col[i];
            end
        end
        w_active = (r_hcnt < H_ACT_END) && (r_vcnt < V_ACT_END);
    end

    // Colour and syncs registered together from the same counter values.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_pixel <= 12'h000;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
        end else begin
            r_pixel <= w_active ? w_color : 12'h000;
            r_hsync <= !((r_hcnt >= HS_FIRST) && (r_hcnt <= HS_LAST));
            r_vsync <= !((r_vcnt >= VS_FIRST) && (r_vcnt <= VS_LAST));
        end
    end

endmodule

// File: tb/tb_axi2gpu.sv
// Bench for axi2gpu: instance A uses the default 640x480 timing (AXI and
// horizontal timing checks); instance B shares the same AXI bus but uses a
// shrunken raster so sprite positions and whole frames fit in a short run.
`timescale 1ns/1ps
module tb_axi2gpu;

    localparam int A_DIV = 4;
    localparam int A_HT  = 800;
    localparam int A_VT  = 525;
    localparam int B_DIV = 2;
    localparam int B_HT  = 104 + 2 + 4 + 2;
    localparam int B_VT  = 88 + 1 + 2 + 1;
    localparam int B_FRAME = B_HT * B_VT * B_DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  awaddr = '0;
    logic        awvalid = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        bready = 1'b0;
    logic [6:0]  araddr = '0;
    logic        arvalid = 1'b0;
    logic        rready = 1'b0;

    logic        a_awready, a_wready, a_bvalid, a_arready, a_rvalid, a_hs, a_vs;
    logic [1:0]  a_bresp, a_rresp;
    logic [31:0] a_rdata;
    logic [11:0] a_pix;
    logic        b_awready, b_wready, b_bvalid, b_arready, b_rvalid, b_hs, b_vs;
    logic [1:0]  b_bresp, b_rresp;
    logic [31:0] b_rdata;
    logic [11:0] b_pix;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    axi2gpu u_a (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
        .s00_axi_awaddr(awaddr), .s00_axi_awprot(3'b000), .s00_axi_awvalid(awvalid),
        .s00_axi_awready(a_awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
        .s00_axi_wvalid(wvalid), .s00_axi_wready(a_wready), .s00_axi_bresp(a_bresp),
        .s00_axi_bvalid(a_bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
        .s00_axi_arprot(3'b000), .s00_axi_arvalid(arvalid), .s00_axi_arready(a_arready),
        .s00_axi_rdata(a_rdata), .s00_axi_rresp(a_rresp), .s00_axi_rvalid(a_rvalid),
        .s00_axi_rready(rready), .pixel_send(a_pix), .h_sync(a_hs), .v_sync(a_vs)
    );

    axi2gpu #(
        .CLK_DIV(B_DIV), .H_ACTIVE(104), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(88), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) u_b (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
        .s00_axi_awaddr(awaddr), .s00_axi_awprot(3'b000), .s00_axi_awvalid(awvalid),
        .s00_axi_awready(b_awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
        .s00_axi_wvalid(wvalid), .s00_axi_wready(b_wready), .s00_axi_bresp(b_bresp),
        .s00_axi_bvalid(b_bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
        .s00_axi_arprot(3'b000), .s00_axi_arvalid(arvalid), .s00_axi_arready(b_arready),
        .s00_axi_rdata(b_rdata), .s00_axi_rresp(b_rresp), .s00_axi_rvalid(b_rvalid),
        .s00_axi_rready(rready), .pixel_send(b_pix), .h_sync(b_hs), .v_sync(b_vs)
    );

    // Reference scan position: *_eh/*_ev is the position the outputs show now.
    int a_div, a_h, a_v, a_eh, a_ev;
    int b_div, b_h, b_v, b_eh, b_ev;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_div <= 0; a_h <= 0; a_v <= 0; a_eh <= 0; a_ev <= 0;
        end else begin
            a_eh <= a_h;
            a_ev <= a_v;
            if (a_div == A_DIV - 1) begin
                a_div <= 0;
                if (a_h == A_HT - 1) begin
                    a_h <= 0;
                    a_v <= (a_v == A_VT - 1) ? 0 : a_v + 1;
                end else a_h <= a_h + 1;
            end else a_div <= a_div + 1;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_div <= 0; b_h <= 0; b_v <= 0; b_eh <= 0; b_ev <= 0;
        end else begin
            b_eh <= b_h;
            b_ev <= b_v;
            if (b_div == B_DIV - 1) begin
                b_div <= 0;
                if (b_h == B_HT - 1) begin
                    b_h <= 0;
                    b_v <= (b_v == B_VT - 1) ? 0 : b_v + 1;
                end else b_h <= b_h + 1;
            end else b_div <= b_div + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // Wait (at negedges) until instance A (sel_a=1) or B shows position (h,v).
    task automatic wait_pos(input bit sel_a, input int h, input int v, input int limit);
        bit ok = 1'b0;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if (sel_a ? (a_eh == h && a_ev == v) : (b_eh == h && b_ev == v)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout($sformatf("wait_pos_%0d_%0d", h, v));
    endtask

    // which: 0 = A h_sync, 1 = B v_sync.
    task automatic wait_sig(input int which, input logic val, input int limit,
                            input string name);
        bit ok = 1'b0;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if (((which == 0) ? a_hs : b_vs) === val) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout(name);
    endtask

    task automatic wait_awready(input string name);
        int n = 0;
        while (a_awready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (a_awready !== 1'b1) timeout(name);
    endtask

    task automatic axi_write(input logic [6:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
        @(negedge clk);
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
        wait_awready("awready_rise");
        check("wready_with_awready", {31'd0, a_wready}, 32'd1);
        check("bvalid_before_hs", {31'd0, a_bvalid}, 32'd0);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        check("bvalid_after_hs", {31'd0, a_bvalid}, 32'd1);
        check("bresp", {30'd0, a_bresp}, 32'd0);
        check("awready_pulse", {31'd0, a_awready}, 32'd0);
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check("bvalid_cleared", {31'd0, a_bvalid}, 32'd0);
    endtask

    task automatic axi_read(input logic [6:0] addr, output logic [31:0] data);
        int n = 0;
        @(negedge clk);
        araddr = addr; arvalid = 1'b1;
        while (a_arready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (a_arready !== 1'b1) timeout("arready_rise");
        @(negedge clk);
        arvalid = 1'b0;
        check("rvalid_after_hs", {31'd0, a_rvalid}, 32'd1);
        check("rresp", {30'd0, a_rresp}, 32'd0);
        data = a_rdata;
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        check("rvalid_cleared", {31'd0, a_rvalid}, 32'd0);
    endtask

    typedef struct {
        int          h;
        int          v;
        logic [11:0] pix;
        logic        hs;
        logic        vs;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [31:0] rd;
        bit          seen;
        int          t0;
        int          t1;

        // Sprite 0: x=50 y=40 w=52 h=45 colour 0x003; B hsync 106..109, vsync rows 89..90.
        vecs[0] = '{h: 49,  v: 40, pix: 12'hABC, hs: 1'b1, vs: 1'b1};
        vecs[1] = '{h: 50,  v: 40, pix: 12'h003, hs: 1'b1, vs: 1'b1};
        vecs[2] = '{h: 102, v: 40, pix: 12'hABC, hs: 1'b1, vs: 1'b1};
        vecs[3] = '{h: 106, v: 40, pix: 12'h000, hs: 1'b0, vs: 1'b1};
        vecs[4] = '{h: 101, v: 84, pix: 12'h003, hs: 1'b1, vs: 1'b1};
        vecs[5] = '{h: 50,  v: 85, pix: 12'hABC, hs: 1'b1, vs: 1'b1};
        vecs[6] = '{h: 10,  v: 90, pix: 12'h000, hs: 1'b1, vs: 1'b0};

        repeat (200) @(negedge clk);
        check("rst_a_pixel", {20'd0, a_pix}, 32'd0);
        check("rst_a_hsync", {31'd0, a_hs}, 32'd1);
        check("rst_a_vsync", {31'd0, a_vs}, 32'd1);
        check("rst_a_axi", {27'd0, a_awready, a_wready, a_bvalid, a_arready, a_rvalid}, 32'd0);
        check("rst_b_pixel", {20'd0, b_pix}, 32'd0);
        check("rst_b_syncs", {30'd0, b_hs, b_vs}, 32'd3);
        rst_n = 1'b1;

        axi_write(7'h00, 32'h0000_0ABC, 4'hF);
        axi_read(7'h00, rd);
        check("read_reg0", rd, 32'h0000_0ABC);

        // Background-only checks and horizontal timing on the full-size instance.
        wait_pos(1'b1, 100, 1, 8000);
        check("a_bg_pixel", {20'd0, a_pix}, 32'h0ABC);
        check("a_bg_syncs", {30'd0, a_hs, a_vs}, 32'd3);
        wait_sig(0, 1'b0, 4000, "a_hsync_fall");
        t0 = cyc;
        check("a_hsync_fall_pos", a_eh, 32'd656);
        check("a_blank_pixel", {20'd0, a_pix}, 32'd0);
        wait_sig(0, 1'b1, 4000, "a_hsync_rise");
        check("a_hsync_low_aclk", cyc - t0, 32'd384);
        wait_sig(0, 1'b0, 4000, "a_hsync_fall2");
        check("a_line_aclk", cyc - t0, 32'd3200);

        axi_write(7'h10, {2'd0, 10'd52, 10'd40, 10'd50}, 4'hF);
        axi_write(7'h14, {22'd3, 10'd45}, 4'hF);
        axi_write(7'h18, 32'h0, 4'hF);
        axi_write(7'h0C, 32'h1, 4'hF);
        for (int i = 0; i < 7; i++) begin
            wait_pos(1'b0, vecs[i].h, vecs[i].v, 2 * B_FRAME);
            check($sformatf("vec%0d_pixel", i), {20'd0, b_pix}, {20'd0, vecs[i].pix});
            check($sformatf("vec%0d_syncs", i), {30'd0, b_hs, b_vs},
                  {30'd0, vecs[i].hs, vecs[i].vs});
        end

        // Overlapping sprites 0/1 plus zero-width sprite 2 and zero-height sprite 3.
        axi_write(7'h14, {10'd0, 12'hF00, 10'd45}, 4'hF);
        axi_write(7'h1C, {2'd0, 10'd52, 10'd40, 10'd50}, 4'hF);
        axi_write(7'h20, {10'd0, 12'h0F0, 10'd45}, 4'hF);
        axi_write(7'h28, 32'h0, 4'hF);
        axi_write(7'h2C, {10'd0, 12'h00F, 10'd100}, 4'hF);
        axi_write(7'h34, {2'd0, 10'd100, 10'd0, 10'd0}, 4'hF);
        axi_write(7'h38, {10'd0, 12'hFFF, 10'd0}, 4'hF);
        axi_write(7'h0C, 32'hF, 4'hF);
        wait_pos(1'b0, 0, 5, 2 * B_FRAME);
        check("empty_sprites_no_hit", {20'd0, b_pix}, 32'h0ABC);
        wait_pos(1'b0, 60, 50, 2 * B_FRAME);
        check("overlap_low_index", {20'd0, b_pix}, 32'h0F00);
        axi_write(7'h0C, 32'hE, 4'hF);
        wait_pos(1'b0, 60, 70, 2 * B_FRAME);
        check("overlap_bit0_clear", {20'd0, b_pix}, 32'h00F0);

        // Byte strobes.
        axi_write(7'h04, 32'h0, 4'hF);
        axi_write(7'h04, 32'hFFFF_FFFF, 4'b0001);
        axi_read(7'h04, rd);
        check("strb_lane0", rd, 32'h0000_00FF);
        axi_write(7'h05, 32'h1234_5678, 4'b0000);
        axi_read(7'h04, rd);
        check("strb_none", rd, 32'h0000_00FF);
        axi_write(7'h04, 32'hAABB_CCDD, 4'b0100);
        axi_read(7'h04, rd);
        check("strb_lane2", rd, 32'h00BB_00FF);

        // A second write must wait while the first response is unacknowledged.
        @(negedge clk);
        awaddr = 7'h08; wdata = 32'h11; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        wait_awready("blk_awready1");
        @(negedge clk);
        wdata = 32'h22;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (a_awready !== 1'b0) seen = 1'b1;
        end
        check("no_accept_while_bvalid", {31'd0, seen}, 32'd0);
        check("bvalid_holds", {31'd0, a_bvalid}, 32'd1);
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        wait_awready("blk_awready2");
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        check("blk_second_bvalid", {31'd0, a_bvalid}, 32'd1);
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        axi_read(7'h08, rd);
        check("blk_second_data", rd, 32'h22);

        // Vertical timing on the shrunken raster.
        wait_sig(1, 1'b0, 2 * B_FRAME, "b_vsync_fall");
        t0 = cyc;
        check("b_vsync_fall_row", b_ev, 32'd89);
        check("b_vsync_fall_col", b_eh, 32'd0);
        wait_sig(1, 1'b1, 2 * B_FRAME, "b_vsync_rise");
        t1 = cyc;
        check("b_vsync_low_aclk", t1 - t0, 32'(2 * B_HT * B_DIV));
        wait_sig(1, 1'b0, 2 * B_FRAME, "b_vsync_fall2");
        check("b_frame_aclk", cyc - t0, 32'(B_FRAME));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
